vga_sync: RTL

//  VGA 640x480@60 timing generator and pixel output stage for the Flappy Bird display.

---
 rtl/vga_sync_if.sv | 33 +++
 rtl/vga_sync.sv | 110 +++++++++++
 2 files changed

// File: rtl/vga_sync_if.sv
// Purpose: renderer/DAC-side signal bundle of the VGA timing generator.
//   master (vga_sync): drives scan coordinates, video_on, ticks, sync and colour pins;
//                      samples the renderer colour channels.
//   slave  (renderer/DAC side): the mirror image.
interface vga_sync_if;
   localparam int unsigned CRD_W = 10;

   logic             red_ch;
   logic             green_ch;
   logic             blue_ch;
   logic [CRD_W-1:0] x_crd;
   logic [CRD_W-1:0] y_crd;
   logic             video_on;
   logic             pix_tick;
   logic             frame_tick;
   logic             vga_hsync;
   logic             vga_vsync;
   logic             vga_r;
   logic             vga_g;
   logic             vga_b;

   modport master (
      input  red_ch, green_ch, blue_ch,
      output x_crd, y_crd, video_on, pix_tick, frame_tick,
      output vga_hsync, vga_vsync, vga_r, vga_g, vga_b
   );

   modport slave (
      output red_ch, green_ch, blue_ch,
      input  x_crd, y_crd, video_on, pix_tick, frame_tick,
      input  vga_hsync, vga_vsync, vga_r, vga_g, vga_b
   );
endinterface

// File: rtl/vga_sync.sv
// Purpose: 640x480@60 VGA timing generator and registered pixel output stage.
// Ports:
//   clk  - system clock (100 MHz nominal)
//   rst  - synchronous reset, active-high
//   bus  - vga_sync_if.master: renderer colours in; scan coordinates, video_on,
//          pix_tick, frame_tick, hsync/vsync and blanked r/g/b out.
module vga_sync #(
   parameter int unsigned CLK_DIV   = 4,
   parameter int unsigned H_VISIBLE = 640,
   parameter int unsigned H_FRONT   = 16,
   parameter int unsigned H_SYNC    = 96,
   parameter int unsigned H_BACK    = 48,
   parameter int unsigned V_VISIBLE = 480,
   parameter int unsigned V_FRONT   = 10,
   parameter int unsigned V_SYNC    = 2,
   parameter int unsigned V_BACK    = 33,
   parameter bit          SYNC_POL  = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   vga_sync_if.master bus
);
   localparam int unsigned CRD_W   = 10;
   localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
   localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [CRD_W-1:0] X_LAST   = CRD_W'(H_TOTAL - 1);
   localparam logic [CRD_W-1:0] Y_LAST   = CRD_W'(V_TOTAL - 1);
   localparam logic [CRD_W-1:0] X_VIS    = CRD_W'(H_VISIBLE);
   localparam logic [CRD_W-1:0] Y_VIS    = CRD_W'(V_VISIBLE);
   localparam logic [CRD_W-1:0] HS_BEG   = CRD_W'(H_VISIBLE + H_FRONT);
   localparam logic [CRD_W-1:0] HS_END   = CRD_W'(H_VISIBLE + H_FRONT + H_SYNC - 1);
   localparam logic [CRD_W-1:0] VS_BEG   = CRD_W'(V_VISIBLE + V_FRONT);
   localparam logic [CRD_W-1:0] VS_END   = CRD_W'(V_VISIBLE + V_FRONT + V_SYNC - 1);

   logic [DIV_W-1:0] div_cnt, div_nxt;
   logic             tick_q, tick_nxt;
   logic             ftick_q, ftick_nxt;
   logic [CRD_W-1:0] x_q, x_nxt;
   logic [CRD_W-1:0] y_q, y_nxt;
   logic             hs_q, vs_q;
   logic             r_q, g_q, b_q;
   logic             video_on_c;
   logic             in_hs_c, in_vs_c;

   // Next prescaler/coordinate values; pix_tick and frame_tick are registered
   // from these so each flag is high exactly while its condition holds.
   always_comb begin
      div_nxt = (div_cnt == DIV_LAST) ? '0 : div_cnt + DIV_W'(1);
      x_nxt   = x_q;
      y_nxt   = y_q;
      if (tick_q) begin
         if (x_q == X_LAST) begin
            x_nxt = '0;
            y_nxt = (y_q == Y_LAST) ? '0 : y_q + CRD_W'(1);
         end else begin
            x_nxt = x_q + CRD_W'(1);
         end
      end
      tick_nxt  = (div_nxt == DIV_LAST);
      ftick_nxt = tick_nxt && (x_nxt == X_LAST) && (y_nxt == Y_LAST);
   end

   assign video_on_c = (x_q < X_VIS) && (y_q < Y_VIS);
   assign in_hs_c    = (x_q >= HS_BEG) && (x_q <= HS_END);
   assign in_vs_c    = (y_q >= VS_BEG) && (y_q <= VS_END);

   // Timing state plus the pin stage, which captures the pixel being consumed
   // so sync and colour lag the coordinates by one pixel, mutually aligned.
   always_ff @(posedge clk) begin
      if (rst) begin
         div_cnt <= '0;
         tick_q  <= 1'b0;
         ftick_q <= 1'b0;
         x_q     <= '0;
         y_q     <= '0;
         hs_q    <= ~SYNC_POL;
         vs_q    <= ~SYNC_POL;
         r_q     <= 1'b0;
         g_q     <= 1'b0;
         b_q     <= 1'b0;
      end else begin
         div_cnt <= div_nxt;
         tick_q  <= tick_nxt;
         ftick_q <= ftick_nxt;
         x_q     <= x_nxt;
         y_q     <= y_nxt;
         if (tick_q) begin
            hs_q <= in_hs_c ? SYNC_POL : ~SYNC_POL;
            vs_q <= in_vs_c ? SYNC_POL : ~SYNC_POL;
            r_q  <= bus.red_ch   & video_on_c;
            g_q  <= bus.green_ch & video_on_c;
            b_q  <= bus.blue_ch  & video_on_c;
         end
      end
   end

   assign bus.x_crd      = x_q;
   assign bus.y_crd      = y_q;
   assign bus.video_on   = video_on_c;
   assign bus.pix_tick   = tick_q;
   assign bus.frame_tick = ftick_q;
   assign bus.vga_hsync  = hs_q;
   assign bus.vga_vsync  = vs_q;
   assign bus.vga_r      = r_q;
   assign bus.vga_g      = g_q;
   assign bus.vga_b      = b_q;
endmodule
